// File: rtl/pe_feeder_if.sv
// pe_feeder_if: command, RAM read and per-lane operand bus of the PE edge feeder.
//   master: the feeder (takes start/base_addr/k_len/rd_data, drives the rest)
//   slave : the command source / operand RAM / array side
//   start, base_addr, k_len   pass command
//   rd_en, rd_addr, rd_data   operand RAM read port (1-cycle read latency)
//   out_vld, out_data         per-lane skewed operands, lane i on out_data[i]
//   pe_en, busy, done         pass status
interface pe_feeder_if #(
  parameter int N  = 4,
  parameter int AW = 8
);
  logic                  start;
  logic [AW-1:0]         base_addr;
  logic [AW-1:0]         k_len;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [N-1:0][7:0]     rd_data;
  logic [N-1:0]          out_vld;
  logic [N-1:0][7:0]     out_data;
  logic                  pe_en;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, k_len, rd_data,
    output rd_en, rd_addr, out_vld, out_data, pe_en, busy, done
  );

  modport slave (
    output start, base_addr, k_len, rd_data,
    input  rd_en, rd_addr, out_vld, out_data, pe_en, busy, done
  );
endinterface

// File: rtl/pe_feeder.sv
// pe_feeder: systolic edge feeder. On start it reads k_len words from the
// operand RAM, splits each into N byte lanes and drives lane i i cycles later
// than lane 0, pulsing done once the last skewed operand has left.
//   clk, rst_n : clock, async active-low reset
//   bus        : pe_feeder_if.master (command, RAM port, lane outputs, status)

// One lane: a STAGES-deep (vld, data) chain. Valids always shift; each data
// stage only loads when the valid feeding it is set, so a lane holds its
// last byte between operands.
module pe_feeder_lane #(
  parameter int STAGES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  output logic       out_vld,
  output logic [7:0] out_data
);
  logic [STAGES:1]       vld_pipe;
  logic [STAGES:1][7:0]  dat_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      if (in_vld) dat_pipe[1] <= in_data;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_data = dat_pipe[STAGES];
endmodule

module pe_feeder #(
  parameter int N  = 4,
  parameter int AW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_feeder_if.master  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  // Drain counter runs 0..N (N+1 cycles): RAM latency + lane-0 reg + N-1 skew.
  localparam int CW = $clog2(N + 2);

  state_t         state;
  logic [AW-1:0]  base_q;
  logic [AW-1:0]  k_q;
  logic [AW-1:0]  j;        // index of the next read to issue
  logic [CW-1:0]  cnt;
  logic           rd_en_q;
  logic [AW-1:0]  rd_addr_q;
  logic           busy_q;
  logic           done_q;
  logic           rd_vld_d; // rd_en delayed to line up with rd_data

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_q    <= '0;
      k_q       <= '0;
      j         <= '0;
      cnt       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_d  <= 1'b0;
    end else begin
      rd_vld_d <= rd_en_q;
      done_q   <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          busy_q <= 1'b1;
          if (bus.k_len != '0) begin
            // read 0 is issued straight from the command, so j starts at 1
            state     <= FETCH;
            base_q    <= bus.base_addr;
            k_q       <= bus.k_len;
            j         <= AW'(1);
            rd_en_q   <= 1'b1;
            rd_addr_q <= bus.base_addr;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        FETCH: begin
          if (j == k_q) begin
            rd_en_q <= 1'b0;
            cnt     <= '0;
            state   <= DRAIN;
          end else begin
            rd_addr_q <= base_q + j;   // wraps mod 2^AW
            j         <= j + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == CW'(N)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = busy_q;
  assign bus.pe_en   = busy_q;
  assign bus.done    = done_q;

  // Lane i sits i+1 registers behind the RAM return: lane-0 reg plus i skew.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    pe_feeder_lane #(.STAGES(gi + 1)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (rd_vld_d),
      .in_data  (bus.rd_data[gi]),
      .out_vld  (bus.out_vld[gi]),
      .out_data (bus.out_data[gi])
    );
  end
endmodule
